adpll_phase_detector: RTL and testbench
=======================================

// Module: adpll_phase_detector
// PURPOSE
//   Digital phase/frequency detector for the ADPLL loop, directly downstream of the
//   programmable divider: compares reference clock against divided feedback clock.
//   Measures edge-to-edge lead/lag in sampling-clock cycles, emits signed error word
//   with a one-cycle valid strobe, classic up/dn levels, and a lock indicator.
//   Output feeds the loop filter.
// PARAMETERS
//   CNT_W     8  width of phase counter; max magnitude MAXC = 2**CNT_W-1
//   LOCK_TOL  2  |err| <= LOCK_TOL counts as an in-lock measurement
//   LOCK_CNT  8  consecutive in-lock measurements needed to assert locked
// PORTS
//   clk        in   1        sampling clock (fast, free-running)
//   reset_n    in   1        asynchronous, active-low reset
//   enable     in   1        measurement enable
//   ref_in     in   1        reference clock, asynchronous to clk
//   fb_in      in   1        divided feedback clock (freq divider output), asynchronous
//   up         out  1        high while ref leads (state REF_LEAD)
//   dn         out  1        high while fb leads (state FB_LEAD)
//   err        out  CNT_W+1  signed two's-complement phase error, held between strobes
//   err_valid  out  1        one-cycle strobe: new err available
//   sat        out  1        err was saturated (timeout or cycle slip); updated with err_valid
//   locked     out  1        lock indicator
// BEHAVIOUR
//   - Reset (async, reset_n=0): state IDLE, count=0, up=dn=0, err=0, err_valid=0, sat=0,
//     locked=0, lock run counter=0, synchronizer flops=0.
//   - ref_in, fb_in: each through 2-flop synchronizer + edge register; rise pulse =
//     sync2 & ~prev, one clk wide. Identical latency on both paths (cancels in err).
//   - FSM states IDLE, REF_LEAD, FB_LEAD; count is CNT_W-bit unsigned.
//     IDLE: ref_rise&fb_rise -> err=0, err_valid=1, sat=0, stay IDLE.
//           ref_rise only -> REF_LEAD, count=1.  fb_rise only -> FB_LEAD, count=1.
//     REF_LEAD: fb_rise -> err=+count, err_valid=1, sat=0, -> IDLE.
//           ref_rise (no fb_rise; cycle slip) -> err=+MAXC, sat=1, err_valid=1, count=1,
//           stay REF_LEAD. ref_rise&fb_rise together -> treat as fb_rise (close measurement).
//           count==MAXC with no closing edge -> err=+MAXC, sat=1, err_valid=1, -> IDLE.
//           else count=count+1.
//     FB_LEAD: mirror of REF_LEAD with roles swapped and err negative (-count / -MAXC).
//   - Sign: positive err = reference leads = DCO must speed up.
//   - up=1 iff state==REF_LEAD; dn=1 iff state==FB_LEAD (registered, never both high).
//   - Latency: err/err_valid registered on the clk edge that samples the closing rise
//     pulse; edge separation of N clk cycles (1<=N<MAXC) yields |err|=N.
//   - err_valid high exactly one cycle per measurement; err and sat hold otherwise.
//   - Lock: on each err_valid, if !sat and |err|<=LOCK_TOL, run=min(run+1,LOCK_CNT),
//     else run=0. locked = (run==LOCK_CNT), updated on the same edge as err_valid.
//   - enable=0: synchronous force to IDLE, count=0, up=dn=0, no err_valid, run=0,
//     locked=0; err and sat hold. Synchronizers keep running so no false edge on re-enable.
//   - Async reset mid-measurement: all outputs clear immediately; no err_valid on release.
// TESTING
//   1. ref rises, fb rises 5 clk later -> err=+5, err_valid 1 cycle, up high 5 cycles, dn=0.
//   2. fb rises 3 clk before ref -> err=-3 (0x1FD at CNT_W=8), dn high 3 cycles, sat=0.
//   3. ref and fb rise same clk edge -> err=0, err_valid=1, up=dn=0.
//   4. CNT_W=4, ref rise, no fb -> after 15 cycles err=+15, sat=1, err_valid, back to IDLE;
//      second ref rise before fb -> cycle slip err=+15, sat=1, new measurement from count=1.
//   5. 8 measurements with err in {-2..+2} -> locked rises with 8th err_valid;
//      next err=+5 -> locked falls on that err_valid; a sat measurement also clears it.
//   6. reset_n low during REF_LEAD -> up, err_valid, locked 0 immediately; enable low
//      mid-count -> no err_valid, state IDLE; re-enable -> next clean pair measured correctly.

Source files
------------

// File: rtl/adpll_phase_detector_if.sv
// rtl/adpll_phase_detector_if.sv - phase detector control, clock inputs and measurement outputs
interface adpll_phase_detector_if #(
  parameter int CNT_W = 8
);
  logic             enable;
  logic             ref_in;
  logic             fb_in;
  logic             up;
  logic             dn;
  logic [CNT_W:0]   err;
  logic             err_valid;
  logic             sat;
  logic             locked;

  modport master (
    output enable, ref_in, fb_in,
    input  up, dn, err, err_valid, sat, locked
  );

  modport slave (
    input  enable, ref_in, fb_in,
    output up, dn, err, err_valid, sat, locked
  );
endinterface

// File: rtl/adpll_phase_detector.sv
// rtl/adpll_phase_detector.sv - ADPLL phase/frequency detector with signed error word and lock detect
module adpll_phase_detector #(
  parameter int CNT_W    = 8,
  parameter int LOCK_TOL = 2,
  parameter int LOCK_CNT = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  adpll_phase_detector_if.slave bus
);

  localparam logic [CNT_W-1:0] MAXC  = '1;
  localparam logic [CNT_W-1:0] TOL   = CNT_W'(LOCK_TOL);
  localparam int               RUN_W = $clog2(LOCK_CNT + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(LOCK_CNT);

  typedef enum logic [1:0] {IDLE, REF_LEAD, FB_LEAD} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] count, count_n;
  logic [CNT_W:0]   err_q, err_n;
  logic             valid_q, valid_n;
  logic             sat_q, sat_n;
  logic [RUN_W-1:0] run, run_n;
  logic             locked_q, locked_n;

  logic ref_s1, ref_s2, ref_prev;
  logic fb_s1, fb_s2, fb_prev;
  logic ref_rise, fb_rise;

  logic             meas;
  logic             meas_sat;
  logic             meas_neg;
  logic [CNT_W-1:0] meas_mag;

  // Both inputs see the same synchronizer depth so the latency cancels in err.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ref_s1   <= 1'b0;
      ref_s2   <= 1'b0;
      ref_prev <= 1'b0;
      fb_s1    <= 1'b0;
      fb_s2    <= 1'b0;
      fb_prev  <= 1'b0;
    end else begin
      ref_s1   <= bus.ref_in;
      ref_s2   <= ref_s1;
      ref_prev <= ref_s2;
      fb_s1    <= bus.fb_in;
      fb_s2    <= fb_s1;
      fb_prev  <= fb_s2;
    end
  end

  assign ref_rise = ref_s2 & ~ref_prev;
  assign fb_rise  = fb_s2 & ~fb_prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      count    <= '0;
      err_q    <= '0;
      valid_q  <= 1'b0;
      sat_q    <= 1'b0;
      run      <= '0;
      locked_q <= 1'b0;
    end else begin
      state    <= state_n;
      count    <= count_n;
      err_q    <= err_n;
      valid_q  <= valid_n;
      sat_q    <= sat_n;
      run      <= run_n;
      locked_q <= locked_n;
    end
  end

  always_comb begin
    state_n  = state;
    count_n  = count;
    err_n    = err_q;
    sat_n    = sat_q;
    valid_n  = 1'b0;
    run_n    = run;
    meas     = 1'b0;
    meas_sat = 1'b0;
    meas_neg = 1'b0;
    meas_mag = '0;

    if (!bus.enable) begin
      state_n = IDLE;
      count_n = '0;
    end else begin
      case (state)
        IDLE: begin
          if (ref_rise && fb_rise) begin
            meas = 1'b1;
          end else if (ref_rise) begin
            state_n = REF_LEAD;
            count_n = CNT_W'(1);
          end else if (fb_rise) begin
            state_n = FB_LEAD;
            count_n = CNT_W'(1);
          end
        end
        REF_LEAD: begin
          // A closing edge wins over a simultaneous slip edge.
          if (fb_rise) begin
            meas     = 1'b1;
            meas_mag = count;
            state_n  = IDLE;
            count_n  = '0;
          end else if (ref_rise) begin
            meas     = 1'b1;
            meas_sat = 1'b1;
            meas_mag = MAXC;
            count_n  = CNT_W'(1);
          end else if (count == MAXC) begin
            meas     = 1'b1;
            meas_sat = 1'b1;
            meas_mag = MAXC;
            state_n  = IDLE;
            count_n  = '0;
          end else begin
            count_n = count + CNT_W'(1);
          end
        end
        FB_LEAD: begin
          meas_neg = 1'b1;
          if (ref_rise) begin
            meas     = 1'b1;
            meas_mag = count;
            state_n  = IDLE;
            count_n  = '0;
          end else if (fb_rise) begin
            meas     = 1'b1;
            meas_sat = 1'b1;
            meas_mag = MAXC;
            count_n  = CNT_W'(1);
          end else if (count == MAXC) begin
            meas     = 1'b1;
            meas_sat = 1'b1;
            meas_mag = MAXC;
            state_n  = IDLE;
            count_n  = '0;
          end else begin
            count_n = count + CNT_W'(1);
          end
        end
        default: begin
          state_n = IDLE;
          count_n = '0;
        end
      endcase
    end

    if (meas) begin
      valid_n = 1'b1;
      sat_n   = meas_sat;
      err_n   = meas_neg ? -{1'b0, meas_mag} : {1'b0, meas_mag};
    end

    if (!bus.enable) begin
      run_n = '0;
    end else if (meas) begin
      if (!meas_sat && (meas_mag <= TOL))
        run_n = (run == RUN_MAX) ? run : run + RUN_W'(1);
      else
        run_n = '0;
    end

    locked_n = (run_n == RUN_MAX);
  end

  assign bus.up        = (state == REF_LEAD);
  assign bus.dn        = (state == FB_LEAD);
  assign bus.err       = err_q;
  assign bus.err_valid = valid_q;
  assign bus.sat       = sat_q;
  assign bus.locked    = locked_q;

endmodule

// File: tb/tb_adpll_phase_detector.sv
// tb/tb_adpll_phase_detector.sv - directed self-checking bench for adpll_phase_detector
module tb_adpll_phase_detector;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  adpll_phase_detector_if #(.CNT_W(8)) bus8 ();
  adpll_phase_detector_if #(.CNT_W(4)) bus4 ();

  adpll_phase_detector #(.CNT_W(8), .LOCK_TOL(2), .LOCK_CNT(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .bus(bus8)
  );
  adpll_phase_detector #(.CNT_W(4), .LOCK_TOL(2), .LOCK_CNT(8)) dut4 (
    .clk(clk), .reset_n(reset_n), .bus(bus4)
  );

  int tests_run = 0;
  int tests_failed = 0;

  int n8_tot = 0, n4_tot = 0, up8_tot = 0, dn8_tot = 0;
  int b_n8, b_n4, b_up8, b_dn8;

  always @(negedge clk) begin
    if (bus8.err_valid) n8_tot++;
    if (bus4.err_valid) n4_tot++;
    if (bus8.up) up8_tot++;
    if (bus8.dn) dn8_tot++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic e, input logic r, input logic f);
    bus8.enable = e; bus8.ref_in = r; bus8.fb_in = f;
    bus4.enable = e; bus4.ref_in = r; bus4.fb_in = f;
  endtask

  task automatic snap();
    b_n8 = n8_tot; b_n4 = n4_tot; b_up8 = up8_tot; b_dn8 = dn8_tot;
  endtask

  // ref rises at step dr, fb at step df; both dropped afterwards
  task automatic pair(input int dr, input int df);
    logic r, f;
    int win;
    r = 1'b0; f = 1'b0;
    win = ((dr > df) ? dr : df) + 6;
    snap();
    for (int t = 0; t < win; t++) begin
      if (t == dr) r = 1'b1;
      if (t == df) f = 1'b1;
      drive(1'b1, r, f);
      step(1);
    end
    drive(1'b1, 1'b0, 1'b0);
    step(5);
  endtask

  task automatic test_reset();
    tests_run++; if ({bus8.up, bus8.dn, bus8.err_valid, bus8.sat, bus8.locked} !== 5'b0) begin tests_failed++; $display("FAIL reset_flags got %b exp 00000", {bus8.up, bus8.dn, bus8.err_valid, bus8.sat, bus8.locked}); end
    tests_run++; if (bus8.err !== 9'h000) begin tests_failed++; $display("FAIL reset_err got %h exp 000", bus8.err); end
    tests_run++; if ({bus4.up, bus4.dn, bus4.err_valid, bus4.err} !== 8'b0) begin tests_failed++; $display("FAIL reset_dut4 got %h exp 00", {bus4.up, bus4.dn, bus4.err_valid, bus4.err}); end
  endtask

  task automatic test_ref_lead();
    pair(0, 5);
    tests_run++; if (bus8.err !== 9'h005) begin tests_failed++; $display("FAIL lead_err got %h exp 005", bus8.err); end
    tests_run++; if (n8_tot - b_n8 != 1) begin tests_failed++; $display("FAIL lead_valid_cycles got %0d exp 1", n8_tot - b_n8); end
    tests_run++; if (up8_tot - b_up8 != 5) begin tests_failed++; $display("FAIL lead_up_cycles got %0d exp 5", up8_tot - b_up8); end
    tests_run++; if (dn8_tot - b_dn8 != 0) begin tests_failed++; $display("FAIL lead_dn_cycles got %0d exp 0", dn8_tot - b_dn8); end
    tests_run++; if (bus8.sat !== 1'b0) begin tests_failed++; $display("FAIL lead_sat got %b exp 0", bus8.sat); end
    tests_run++; if (bus4.err !== 5'h05) begin tests_failed++; $display("FAIL lead_err4 got %h exp 05", bus4.err); end
  endtask

  task automatic test_fb_lead();
    pair(3, 0);
    tests_run++; if (bus8.err !== 9'h1FD) begin tests_failed++; $display("FAIL lag_err got %h exp 1fd", bus8.err); end
    tests_run++; if (dn8_tot - b_dn8 != 3) begin tests_failed++; $display("FAIL lag_dn_cycles got %0d exp 3", dn8_tot - b_dn8); end
    tests_run++; if (up8_tot - b_up8 != 0) begin tests_failed++; $display("FAIL lag_up_cycles got %0d exp 0", up8_tot - b_up8); end
    tests_run++; if (bus8.sat !== 1'b0) begin tests_failed++; $display("FAIL lag_sat got %b exp 0", bus8.sat); end
  endtask

  task automatic test_coincident();
    pair(0, 0);
    tests_run++; if (bus8.err !== 9'h000) begin tests_failed++; $display("FAIL coinc_err got %h exp 000", bus8.err); end
    tests_run++; if (n8_tot - b_n8 != 1) begin tests_failed++; $display("FAIL coinc_valid got %0d exp 1", n8_tot - b_n8); end
    tests_run++; if ((up8_tot - b_up8) + (dn8_tot - b_dn8) != 0) begin tests_failed++; $display("FAIL coinc_updn got %0d exp 0", (up8_tot - b_up8) + (dn8_tot - b_dn8)); end
  endtask

  task automatic test_timeout_slip();
    snap();
    drive(1'b1, 1'b1, 1'b0);
    step(22);
    tests_run++; if (n4_tot - b_n4 != 1) begin tests_failed++; $display("FAIL tmo_valid got %0d exp 1", n4_tot - b_n4); end
    tests_run++; if ({bus4.sat, bus4.err} !== 6'h2F) begin tests_failed++; $display("FAIL tmo_err got %h exp 2f", {bus4.sat, bus4.err}); end
    tests_run++; if (bus4.up !== 1'b0) begin tests_failed++; $display("FAIL tmo_idle got %b exp 0", bus4.up); end
    tests_run++; if (bus8.up !== 1'b1) begin tests_failed++; $display("FAIL tmo_wide_up got %b exp 1", bus8.up); end
    drive(1'b1, 1'b0, 1'b0); step(4);
    drive(1'b1, 1'b1, 1'b0); step(6);
    drive(1'b1, 1'b0, 1'b0); step(4);
    snap();
    drive(1'b1, 1'b1, 1'b0); step(4);
    tests_run++; if (n4_tot - b_n4 != 1) begin tests_failed++; $display("FAIL slip_valid got %0d exp 1", n4_tot - b_n4); end
    tests_run++; if ({bus4.sat, bus4.err} !== 6'h2F) begin tests_failed++; $display("FAIL slip_err got %h exp 2f", {bus4.sat, bus4.err}); end
    tests_run++; if (bus4.up !== 1'b1) begin tests_failed++; $display("FAIL slip_up got %b exp 1", bus4.up); end
    drive(1'b1, 1'b1, 1'b1); step(6);
    tests_run++; if ({bus4.sat, bus4.err} !== 6'h04) begin tests_failed++; $display("FAIL slip_next got %h exp 04", {bus4.sat, bus4.err}); end
    drive(1'b1, 1'b0, 1'b0); step(5);
  endtask

  task automatic lock_run(input string tag);
    int e[8] = '{0, 1, -1, 2, -2, 0, 1, 2};
    logic [8:0] x;
    for (int i = 0; i < 8; i++) begin
      if (e[i] >= 0) pair(0, e[i]); else pair(-e[i], 0);
      x = 9'(e[i]);
      tests_run++; if (bus8.err !== x || bus8.locked !== (i == 7)) begin tests_failed++; $display("FAIL %s_%0d got err %h locked %b exp err %h locked %b", tag, i, bus8.err, bus8.locked, x, (i == 7)); end
    end
  endtask

  task automatic test_lock();
    lock_run("lock_a");
    pair(0, 5);
    tests_run++; if ({bus8.locked, bus8.err} !== 10'h005) begin tests_failed++; $display("FAIL lock_drop got %h exp 005", {bus8.locked, bus8.err}); end
    lock_run("lock_b");
    drive(1'b1, 1'b1, 1'b0); step(6);
    drive(1'b1, 1'b0, 1'b0); step(4);
    drive(1'b1, 1'b1, 1'b0); step(6);
    tests_run++; if ({bus8.sat, bus8.locked} !== 2'b10) begin tests_failed++; $display("FAIL lock_sat_clear got %b exp 10", {bus8.sat, bus8.locked}); end
    drive(1'b1, 1'b1, 1'b1); step(6);
    drive(1'b1, 1'b0, 1'b0); step(5);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 8; i++) pair(0, 0);
    tests_run++; if (bus8.locked !== 1'b1) begin tests_failed++; $display("FAIL rst_prelock got %b exp 1", bus8.locked); end
    drive(1'b1, 1'b1, 1'b0); step(6);
    tests_run++; if (bus8.up !== 1'b1) begin tests_failed++; $display("FAIL rst_preup got %b exp 1", bus8.up); end
    #3 reset_n = 1'b0;
    #1;
    tests_run++; if ({bus8.up, bus8.err_valid, bus8.locked, bus8.err} !== 12'h000) begin tests_failed++; $display("FAIL rst_clear got %h exp 000", {bus8.up, bus8.err_valid, bus8.locked, bus8.err}); end
    step(2);
    drive(1'b1, 1'b0, 1'b0);
    step(2);
    snap();
    reset_n = 1'b1;
    step(10);
    tests_run++; if (n8_tot - b_n8 != 0) begin tests_failed++; $display("FAIL rst_release_valid got %0d exp 0", n8_tot - b_n8); end
  endtask

  task automatic test_enable();
    snap();
    drive(1'b1, 1'b1, 1'b0); step(6);
    tests_run++; if (bus8.up !== 1'b1) begin tests_failed++; $display("FAIL en_preup got %b exp 1", bus8.up); end
    drive(1'b0, 1'b1, 1'b0); step(1);
    tests_run++; if ({bus8.up, bus8.dn} !== 2'b00) begin tests_failed++; $display("FAIL en_idle got %b exp 00", {bus8.up, bus8.dn}); end
    drive(1'b0, 1'b1, 1'b1); step(8);
    tests_run++; if (n8_tot - b_n8 != 0 || bus8.dn !== 1'b0) begin tests_failed++; $display("FAIL en_quiet got %0d/%b exp 0/0", n8_tot - b_n8, bus8.dn); end
    drive(1'b0, 1'b0, 1'b0); step(5);
    drive(1'b1, 1'b0, 1'b0); step(3);
    pair(0, 4);
    tests_run++; if (bus8.err !== 9'h004 || n8_tot - b_n8 != 1) begin tests_failed++; $display("FAIL en_reenable got %h/%0d exp 004/1", bus8.err, n8_tot - b_n8); end
  endtask

  initial begin
    reset_n = 1'b0;
    drive(1'b1, 1'b0, 1'b0);
    step(3);
    test_reset();
    reset_n = 1'b1;
    step(3);
    test_ref_lead();
    test_fb_lead();
    test_coincident();
    test_timeout_slip();
    test_lock();
    test_async_reset();
    test_enable();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
